top_of_mips_for_simulation: RTL and testbench
=============================================

Name: top_of_mips_for_simulation

Overview:
Single-cycle 32-bit MIPS-subset processor top for simulation. Contains an internal instruction ROM preloaded with a 4! program, a register file, an ALU with multiplier and a 64-word data RAM. Exposes PC, data-memory bus activity and a debug register-read port, so a bench can check that $s0 (r16) holds 0x18 when PC reaches 0x30.

Parameters:
IMEM_WORDS, 64, instruction ROM depth in words; index = pc[7:2].
DMEM_WORDS, 64, data RAM depth in words; index = addr[7:2].

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-low core reset; clears PC and register file
dispSel  input  5  debug register index
pc  output  32  current program counter
dispDat  output  32  register file[dispSel], combinational
dataaddr  output  32  ALU result (data memory address for lw/sw)
memwrite  output  1  high during a sw instruction
writedata  output  32  register rt read data (sw store data)
reset_Wreg_c  input  1  asynchronous, active-low register-file/write-back reset

Behaviour:
- Reset is asynchronous and active-low. reset low: pc=0 and all 32 registers=0 immediately. Data RAM is not reset.
- reset_Wreg_c low: all registers cleared asynchronously; register writes blocked; pc holds.
- Core advances only when both reset and reset_Wreg_c are high. Each rising clk executes one instruction: register write and memory write commit, then pc updates.
- Reset mid-program restarts at pc=0 with registers zeroed.
- r0 reads 0; writes to r0 ignored. Two combinational read ports.
- Instructions:
  - R-type funct: add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed).
  - SPECIAL2 op 0x1C funct 0x02: mul rd = low 32 bits of rs*rt.
  - addi 0x08: sign-extended immediate.
  - lw 0x23, sw 0x2B: addr = rs + sext(imm).
  - beq 0x04: target = pc+4 + sext(imm)<<2.
  - j 0x02: target = {pc+4[31:28], target, 2'b00}.
  - Anything else executes as NOP.
- Arithmetic is 32-bit wrap-around; no overflow traps.
- Outputs:
  - dataaddr = ALU result every cycle.
  - writedata = rt read data.
  - memwrite = 1 only for sw when the core is enabled.
  - dispDat = reg[dispSel].
  - Reset values: pc=0; dispDat=0; dataaddr and writedata follow decode of ROM[0].
- Data RAM: synchronous write on rising clk when memwrite; combinational read; addresses wrap modulo 256 bytes.
- ROM contents at word addresses 0x00–0x34; all other words 0 (NOP):
  - 0x00: 20100001  addi $s0,$0,1
  - 0x04: 20080004  addi $t0,$0,4
  - 0x08: 11000009  beq $t0,$0,0x30
  - 0x0C: 72088002  mul $s0,$s0,$t0
  - 0x10: 2108FFFF  addi $t0,$t0,-1
  - 0x14: 08000002  j 0x08
  - 0x18–0x2C: 00000000 (NOP)
  - 0x30: AC100004  sw $s0,4($0)
  - 0x34: 0800000D  j 0x34 (halt loop)
- PC must not equal 0x30 before the loop exits. Loop exits after 4 iterations with $s0=0x18.
- PC at ROM end wraps; unreachable in the program.

Test Plan:
- Hold reset low 1 cycle, then release with reset_Wreg_c high → pc=0x00 and then 0x04, 0x08, 0x0C in successive cycles; dispSel=16 gives dispDat=0 then 1.
- Full run, dispSel=5'b10000 → first cycle with pc==0x30 shows dispDat=0x18; pc never 0x30 earlier.
- At pc=0x30 → memwrite=1, dataaddr=0x04, writedata=0x18. Next cycle pc=0x34 and stays 0x34 forever; memwrite=0.
- Hold reset_Wreg_c low for 3 cycles after reset release → pc stays 0 and registers stay 0. After release, program completes identically (0x18 at pc 0x30).
- Assert reset mid-loop (pc=0x10) → pc=0 and dispDat(16)=0 immediately (asynchronous); rerun reaches 0x18 again.
- dispSel=0 at any time → dispDat=0. dispSel=8 at pc=0x30 → $t0=0.

Source files
------------

// File: rtl/top_of_mips_for_simulation.sv
// Single-cycle MIPS-subset core with an internal ROM holding a 4! program,
// a 32x32 register file, an ALU with multiplier and a 64-word data RAM.
module top_of_mips_for_simulation #(
    parameter int IMEM_WORDS = 64,
    parameter int DMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  dispSel,
    output logic [31:0] pc,
    output logic [31:0] dispDat,
    output logic [31:0] dataaddr,
    output logic        memwrite,
    output logic [31:0] writedata,
    input  logic        reset_Wreg_c
);
    localparam int IA = $clog2(IMEM_WORDS);
    localparam int DA = $clog2(DMEM_WORDS);

    localparam logic [5:0] OP_RTYPE    = 6'h00;
    localparam logic [5:0] OP_J        = 6'h02;
    localparam logic [5:0] OP_BEQ      = 6'h04;
    localparam logic [5:0] OP_ADDI     = 6'h08;
    localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
    localparam logic [5:0] OP_LW       = 6'h23;
    localparam logic [5:0] OP_SW       = 6'h2B;

    localparam logic [5:0] FN_MUL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    logic [31:0] pc_q, pc_d;
    logic [31:0] rf_q [32];
    logic [31:0] dmem_q [DMEM_WORDS];
    logic [31:0] instr;

    // Program ROM: computes 4! into $s0, stores it to address 4, then halts.
    always_comb begin
        instr = 32'h0000_0000;
        case (int'(pc_q[IA+1:2]))
            0:  instr = 32'h2010_0001;
            1:  instr = 32'h2008_0004;
            2:  instr = 32'h1100_0009;
            3:  instr = 32'h7208_8002;
            4:  instr = 32'h2108_FFFF;
            5:  instr = 32'h0800_0002;
            12: instr = 32'hAC10_0004;
            13: instr = 32'h0800_000D;
            default: instr = 32'h0000_0000;
        endcase
    end

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] sext_imm, rs_dat, rt_dat, pc_plus4;

    assign op       = instr[31:26];
    assign rs       = instr[25:21];
    assign rt       = instr[20:16];
    assign rd       = instr[15:11];
    assign funct    = instr[5:0];
    assign sext_imm = {{16{instr[15]}}, instr[15:0]};
    assign rs_dat   = rf_q[rs];
    assign rt_dat   = rf_q[rt];
    assign pc_plus4 = pc_q + 32'd4;

    logic [31:0] alu_res, wb_dat;
    logic [4:0]  wa;
    logic        rf_we, is_lw, is_sw, take_branch, is_jump;

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        alu_res     = rs_dat + sext_imm;
        wa          = rt;
        rf_we       = 1'b0;
        is_lw       = 1'b0;
        is_sw       = 1'b0;
        take_branch = 1'b0;
        is_jump     = 1'b0;
        case (op)
            OP_RTYPE: begin
                wa = rd;
                case (funct)
                    FN_ADD: begin alu_res = rs_dat + rt_dat; rf_we = 1'b1; end
                    FN_SUB: begin alu_res = rs_dat - rt_dat; rf_we = 1'b1; end
                    FN_AND: begin alu_res = rs_dat & rt_dat; rf_we = 1'b1; end
                    FN_OR:  begin alu_res = rs_dat | rt_dat; rf_we = 1'b1; end
                    FN_SLT: begin
                        alu_res = {31'd0, $signed(rs_dat) < $signed(rt_dat)};
                        rf_we   = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP_SPECIAL2: begin
                wa = rd;
                if (funct == FN_MUL) begin
                    alu_res = rs_dat * rt_dat;
                    rf_we   = 1'b1;
                end
            end
            OP_ADDI: rf_we = 1'b1;
            OP_LW: begin
                rf_we = 1'b1;
                is_lw = 1'b1;
            end
            OP_SW:  is_sw = 1'b1;
            OP_BEQ: begin
                alu_res     = rs_dat - rt_dat;
                take_branch = (rs_dat == rt_dat);
            end
            OP_J:   is_jump = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        pc_d = pc_plus4;
        if (take_branch) pc_d = pc_plus4 + {sext_imm[29:0], 2'b00};
        else if (is_jump) pc_d = {pc_plus4[31:28], instr[25:0], 2'b00};
    end

    assign wb_dat    = is_lw ? dmem_q[alu_res[DA+1:2]] : alu_res;
    assign memwrite  = is_sw & reset & reset_Wreg_c;
    assign pc        = pc_q;
    assign dataaddr  = alu_res;
    assign writedata = rt_dat;
    assign dispDat   = rf_q[dispSel];

    // PC freezes while only the write-back reset is held.
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pc_q <= 32'd0;
        else if (reset_Wreg_c) pc_q <= pc_d;
    end

    always_ff @(posedge clk or negedge reset or negedge reset_Wreg_c) begin
        if (!reset || !reset_Wreg_c) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
        end else if (rf_we && wa != 5'd0) begin
            rf_q[wa] <= wb_dat;
        end
    end

    // NOTE: the data RAM has no reset; its contents are undefined until written.
    always_ff @(posedge clk) begin
        if (memwrite) dmem_q[alu_res[DA+1:2]] <= writedata;
    end
endmodule

// File: tb/tb_top_of_mips_for_simulation.sv
// Directed bench: steps the 4! program against a hand-computed trace table
// and exercises both resets mid-run.
module tb_top_of_mips_for_simulation;
    logic        clk = 1'b0;
    logic        reset;
    logic        reset_Wreg_c;
    logic [4:0]  dispSel;
    logic [31:0] pc, dispDat, dataaddr, writedata;
    logic        memwrite;

    int vec_count  = 0;
    int miscompares = 0;

    top_of_mips_for_simulation dut (
        .clk          (clk),
        .reset        (reset),
        .dispSel      (dispSel),
        .pc           (pc),
        .dispDat      (dispDat),
        .dataaddr     (dataaddr),
        .memwrite     (memwrite),
        .writedata    (writedata),
        .reset_Wreg_c (reset_Wreg_c)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] s0;
        logic [31:0] t0;
        logic        mw;
    } vec_t;

    vec_t tbl [21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expects to be entered at a negedge with the core sitting at pc=0, registers clear.
    task automatic run_table(input string tag);
        for (int i = 0; i < 21; i++) begin
            dispSel = 5'd16;
            #1;
            check($sformatf("%s pc step%0d", tag, i), pc, tbl[i].pc);
            check($sformatf("%s s0 step%0d", tag, i), dispDat, tbl[i].s0);
            check($sformatf("%s memwrite step%0d", tag, i), {31'd0, memwrite}, {31'd0, tbl[i].mw});
            if (tbl[i].mw) begin
                check($sformatf("%s dataaddr step%0d", tag, i), dataaddr, 32'h4);
                check($sformatf("%s writedata step%0d", tag, i), writedata, 32'h18);
            end
            dispSel = 5'd8;
            #1;
            check($sformatf("%s t0 step%0d", tag, i), dispDat, tbl[i].t0);
            dispSel = 5'd16;
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        bit found;
        tbl[0]  = '{32'h00, 32'd0,  32'd0, 1'b0};
        tbl[1]  = '{32'h04, 32'd1,  32'd0, 1'b0};
        tbl[2]  = '{32'h08, 32'd1,  32'd4, 1'b0};
        tbl[3]  = '{32'h0C, 32'd1,  32'd4, 1'b0};
        tbl[4]  = '{32'h10, 32'd4,  32'd4, 1'b0};
        tbl[5]  = '{32'h14, 32'd4,  32'd3, 1'b0};
        tbl[6]  = '{32'h08, 32'd4,  32'd3, 1'b0};
        tbl[7]  = '{32'h0C, 32'd4,  32'd3, 1'b0};
        tbl[8]  = '{32'h10, 32'd12, 32'd3, 1'b0};
        tbl[9]  = '{32'h14, 32'd12, 32'd2, 1'b0};
        tbl[10] = '{32'h08, 32'd12, 32'd2, 1'b0};
        tbl[11] = '{32'h0C, 32'd12, 32'd2, 1'b0};
        tbl[12] = '{32'h10, 32'd24, 32'd2, 1'b0};
        tbl[13] = '{32'h14, 32'd24, 32'd1, 1'b0};
        tbl[14] = '{32'h08, 32'd24, 32'd1, 1'b0};
        tbl[15] = '{32'h0C, 32'd24, 32'd1, 1'b0};
        tbl[16] = '{32'h10, 32'd24, 32'd1, 1'b0};
        tbl[17] = '{32'h14, 32'd24, 32'd0, 1'b0};
        tbl[18] = '{32'h08, 32'd24, 32'd0, 1'b0};
        tbl[19] = '{32'h30, 32'd24, 32'd0, 1'b1};
        tbl[20] = '{32'h34, 32'd24, 32'd0, 1'b0};

        // Power-on reset: outputs reflect decode of ROM[0] (addi $s0,$0,1).
        reset        = 1'b0;
        reset_Wreg_c = 1'b1;
        dispSel      = 5'd16;
        @(negedge clk);
        check("reset pc", pc, 32'h0);
        check("reset dispDat", dispDat, 32'h0);
        check("reset dataaddr", dataaddr, 32'h1);
        check("reset writedata", writedata, 32'h0);
        check("reset memwrite", {31'd0, memwrite}, 32'h0);
        reset = 1'b1;
        run_table("run1");

        // Halt loop: pc parks at 0x34 and no further stores occur.
        for (int i = 0; i < 5; i++) begin
            check($sformatf("halt pc %0d", i), pc, 32'h34);
            check($sformatf("halt memwrite %0d", i), {31'd0, memwrite}, 32'h0);
            @(posedge clk);
            @(negedge clk);
        end
        dispSel = 5'd0;
        #1;
        check("r0 reads zero", dispDat, 32'h0);
        dispSel = 5'd16;
        #1;
        check("s0 kept in halt", dispDat, 32'h18);

        // Core reset released while write-back reset is still held for 3 cycles.
        @(negedge clk);
        reset        = 1'b0;
        reset_Wreg_c = 1'b0;
        #1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("wreg hold pc %0d", i), pc, 32'h0);
            check($sformatf("wreg hold s0 %0d", i), dispDat, 32'h0);
            check($sformatf("wreg hold memwrite %0d", i), {31'd0, memwrite}, 32'h0);
        end
        reset_Wreg_c = 1'b1;
        run_table("run2");

        // Asynchronous reset mid-loop, then full rerun.
        @(negedge clk);
        reset = 1'b0;
        #1;
        reset = 1'b1;
        @(negedge clk);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (pc == 32'h10) found = 1'b1;
            else begin
                @(posedge clk);
                @(negedge clk);
            end
        end
        check("reached pc 0x10", {31'd0, found}, 32'h1);
        #1;
        check("s0 before async reset", dispDat, 32'h4);
        reset = 1'b0;
        #1;
        check("async reset pc", pc, 32'h0);
        check("async reset s0", dispDat, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        run_table("run3");

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end
endmodule
